// File: rtl/ovflo_tally_pkg.sv
// rtl/ovflo_tally_pkg.sv - shared types and record layout for the overflow tally block
package ovflo_tally_pkg;

  // Default widths for the tally, the sequence number and the interval field
  localparam int DEF_CNT_W = 8;
  localparam int DEF_SEQ_W = 4;
  localparam int DEF_TS_W  = 16;

  // A report record is {seq, cyc}: the interval sits in the low bits
  localparam int REC_W   = DEF_SEQ_W + DEF_TS_W;
  localparam int CYC_OFS = 0;
  localparam int SEQ_OFS = CYC_OFS + DEF_TS_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ovflo_tally_if.sv
// rtl/ovflo_tally_if.sv - valid/ready report stream between the tally and its consumer
interface ovflo_tally_if
  import ovflo_tally_pkg::*;
#(
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int TS_W  = DEF_TS_W
);

  logic             out_valid;
  logic             out_ready;
  logic [SEQ_W-1:0] out_seq;
  logic [TS_W-1:0]  out_cyc;

  modport master (
    output out_valid,
    output out_seq,
    output out_cyc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_seq,
    input  out_cyc,
    output out_ready
  );

endinterface

// File: rtl/ovflo_rpt_fifo.sv
// rtl/ovflo_rpt_fifo.sv - two-entry report buffer that drops pushes when full and not draining
module ovflo_rpt_fifo
  import ovflo_tally_pkg::*;
#(
  parameter int W = REC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // A pop in the same cycle frees the slot, so a push into a full buffer is kept
  always_comb begin
    do_pop  = pop & (count != 2'd0);
    do_push = push & ((count != 2'd2) | do_pop);
    drop    = push & ~do_push;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Storage, pointers and occupancy; no bypass, a push is visible next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ovflo_tally.sv
// rtl/ovflo_tally.sv - counts rising edges of ovflo and emits periodic {seq, interval} reports
module ovflo_tally
  import ovflo_tally_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             ovflo,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             lost,
  ovflo_tally_if.master    rpt
);

  localparam int RW      = SEQ_W + TS_W;
  localparam int SEQ_LSB = CYC_OFS + TS_W;

  state_t           state;
  logic             ovf_d;
  logic [SEQ_W-1:0] seq;
  logic [TS_W-1:0]  cyc;

  logic             evt;
  logic             clr;
  logic             terminal;
  logic             push;
  logic [CNT_W-1:0] term_eff;
  logic [CNT_W:0]   cnt_inc;

  logic [RW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             pop;

  // Event and terminal decode; start (without stop) overrides the tally that cycle
  always_comb begin
    evt      = ovflo & ~ovf_d;
    clr      = start & ~stop;
    term_eff = (term == '0) ? CNT_W'(1) : term;
    cnt_inc  = {1'b0, cnt} + (CNT_W + 1)'(1);
    terminal = (cnt_inc >= {1'b0, term_eff});
    push     = (state == RUN) & ~clr & evt & terminal;
  end

  assign pop  = rpt.out_valid & rpt.out_ready;
  assign busy = (state == RUN);

  // Run/idle control, edge register, tally, sequence, interval and sticky loss flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ovf_d <= 1'b0;
      cnt   <= '0;
      seq   <= '0;
      cyc   <= '0;
      lost  <= 1'b0;
    end else begin
      ovf_d <= ovflo;
      if (fifo_drop) begin
        lost <= 1'b1;
      end
      if (stop) begin
        state <= IDLE;
      end else if (start) begin
        state <= RUN;
      end
      if (clr) begin
        cnt  <= '0;
        seq  <= '0;
        lost <= 1'b0;
        cyc  <= TS_W'(1);
      end else if (state == RUN) begin
        if (cyc != '1) begin
          cyc <= cyc + TS_W'(1);
        end
        if (evt) begin
          if (terminal) begin
            cnt <= '0;
            seq <= seq + SEQ_W'(1);
            cyc <= TS_W'(1);
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
      end
    end
  end

  ovflo_rpt_fifo #(
    .W(RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({seq, cyc}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign rpt.out_valid = ~fifo_empty;
  assign rpt.out_seq   = head[SEQ_LSB +: SEQ_W];
  assign rpt.out_cyc   = head[CYC_OFS +: TS_W];

  // A record can only be lost when the buffer is holding two entries
  drop_needs_full: assert property (@(posedge clk) disable iff (rst) fifo_drop |-> fifo_full);

endmodule

// File: tb/tb_ovflo_tally.sv
// tb/tb_ovflo_tally.sv - self-checking bench for ovflo_tally
module tb_ovflo_tally;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       ovflo;
  logic [7:0] term;
  logic [7:0] cnt;
  logic       busy;
  logic       lost;

  int checks;
  int errors;

  ovflo_tally_if #(.SEQ_W(4), .TS_W(16)) rpt_if ();

  ovflo_tally #(.CNT_W(8), .SEQ_W(4), .TS_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .ovflo (ovflo),
    .term  (term),
    .cnt   (cnt),
    .busy  (busy),
    .lost  (lost),
    .rpt   (rpt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] term;
    int         n_evt;
    logic [7:0] exp_cnt;
    logic       exp_valid;
    logic       exp_lost;
  } vec_t;

  typedef struct {
    int seq;
    int cyc;
  } rec_t;

  vec_t vecs [7];

  // reference model state
  bit   m_run;
  int   m_cnt;
  int   m_seq;
  int   m_cyc;
  bit   m_lost;
  bit   m_prev;
  rec_t mq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    ovflo = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse();
    ovflo = 1'b1;
    step();
    ovflo = 1'b0;
    step();
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_seq = 0; m_cyc = 0; m_lost = 0; m_prev = 0;
    mq.delete();
  endtask

  // One clock of the specified behaviour, from the inputs about to be sampled
  task automatic model_edge(input bit s, input bit p, input bit ov, input int t, input bit rdy);
    bit   evt;
    bit   do_push;
    rec_t r;
    int   thr;
    evt = ov && !m_prev;
    do_push = 0;
    if (s && !p) begin
      m_cnt = 0; m_seq = 0; m_lost = 0; m_cyc = 1;
    end else if (m_run) begin
      r.seq = m_seq;
      r.cyc = m_cyc;
      m_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
      if (evt) begin
        thr = (t == 0) ? 1 : t;
        if (m_cnt + 1 >= thr) begin
          do_push = 1;
          m_cnt = 0;
          m_seq = (m_seq + 1) % 16;
          m_cyc = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < 2) mq.push_back(r);
      else m_lost = 1;
    end
    if (p) m_run = 0;
    else if (s) m_run = 1;
    m_prev = ov;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    term = 8'd3;
    rpt_if.out_ready = 1'b0;

    // reset state
    do_reset();
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_lost", 32'(lost), 32'd0);
    check("reset_valid", 32'(rpt_if.out_valid), 32'd0);

    // table of short runs: term, events, expected tally / valid / lost
    vecs[0] = '{8'd3, 2, 8'd2, 1'b0, 1'b0};
    vecs[1] = '{8'd3, 3, 8'd0, 1'b1, 1'b0};
    vecs[2] = '{8'd0, 1, 8'd0, 1'b1, 1'b0};
    vecs[3] = '{8'd5, 4, 8'd4, 1'b0, 1'b0};
    vecs[4] = '{8'd4, 9, 8'd1, 1'b1, 1'b0};
    vecs[5] = '{8'd1, 3, 8'd0, 1'b1, 1'b1};
    vecs[6] = '{8'd2, 7, 8'd1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      rpt_if.out_ready = 1'b0;
      term = vecs[i].term;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < vecs[i].n_evt; k++) pulse();
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_valid", i), 32'(rpt_if.out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_lost", i), 32'(lost), 32'(vecs[i].exp_lost));
    end

    // first report timing: term=3, pulses at 5, 13, 21
    do_reset();
    term = 8'd3;
    rpt_if.out_ready = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      start = (e == 0);
      ovflo = (e == 5 || e == 13);
      step();
    end
    start = 1'b0;
    check("t1_no_early_valid", 32'(rpt_if.out_valid), 32'd0);
    check("t1_cnt_before", 32'(cnt), 32'd2);
    ovflo = 1'b1;
    step();
    ovflo = 1'b0;
    check("t1_valid", 32'(rpt_if.out_valid), 32'd1);
    check("t1_seq", 32'(rpt_if.out_seq), 32'd0);
    check("t1_cyc", 32'(rpt_if.out_cyc), 32'd21);
    check("t1_cnt", 32'(cnt), 32'd0);
    for (int e = 22; e <= 45; e++) begin
      ovflo = (e == 45);
      step();
    end
    ovflo = 1'b0;
    check("t1_cnt_after", 32'(cnt), 32'd1);
    check("t1_drained", 32'(rpt_if.out_valid), 32'd0);

    // held level counts once: term=2, ovflo high 5..9, pulse at 15
    do_reset();
    term = 8'd2;
    rpt_if.out_ready = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      start = (e == 0);
      ovflo = (e >= 5 && e <= 9);
      step();
    end
    start = 1'b0;
    check("t2_held_cnt", 32'(cnt), 32'd1);
    check("t2_held_valid", 32'(rpt_if.out_valid), 32'd0);
    pulse();
    check("t2_valid", 32'(rpt_if.out_valid), 32'd1);
    check("t2_cyc", 32'(rpt_if.out_cyc), 32'd15);

    // full buffer, drop, drain order and sequence after a drop
    do_reset();
    term = 8'd1;
    rpt_if.out_ready = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      start = (e == 0);
      ovflo = (e == 5 || e == 10);
      step();
    end
    start = 1'b0;
    check("t3_lost_before", 32'(lost), 32'd0);
    ovflo = 1'b1;
    step();
    ovflo = 1'b0;
    check("t3_lost", 32'(lost), 32'd1);
    check("t3_head_seq0", 32'(rpt_if.out_seq), 32'd0);
    check("t3_head_cyc0", 32'(rpt_if.out_cyc), 32'd5);
    rpt_if.out_ready = 1'b1;
    step();
    check("t3_head_seq1", 32'(rpt_if.out_seq), 32'd1);
    check("t3_head_cyc1", 32'(rpt_if.out_cyc), 32'd5);
    step();
    check("t3_empty", 32'(rpt_if.out_valid), 32'd0);
    ovflo = 1'b1;
    step();
    ovflo = 1'b0;
    check("t3_next_valid", 32'(rpt_if.out_valid), 32'd1);
    check("t3_next_seq", 32'(rpt_if.out_seq), 32'd3);
    check("t3_lost_sticky", 32'(lost), 32'd1);

    // push into a full buffer while it pops is accepted
    do_reset();
    term = 8'd1;
    rpt_if.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    pulse();
    pulse();
    check("t4_full_seq0", 32'(rpt_if.out_seq), 32'd0);
    ovflo = 1'b1;
    rpt_if.out_ready = 1'b1;
    step();
    ovflo = 1'b0;
    rpt_if.out_ready = 1'b0;
    check("t4_lost", 32'(lost), 32'd0);
    check("t4_head_seq1", 32'(rpt_if.out_seq), 32'd1);
    rpt_if.out_ready = 1'b1;
    step();
    check("t4_head_seq2", 32'(rpt_if.out_seq), 32'd2);
    check("t4_still_valid", 32'(rpt_if.out_valid), 32'd1);
    step();
    check("t4_empty", 32'(rpt_if.out_valid), 32'd0);

    // stop mid-count, start+stop together, then restart
    do_reset();
    term = 8'd5;
    rpt_if.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    pulse();
    pulse();
    stop = 1'b1;
    step();
    stop = 1'b0;
    pulse();
    pulse();
    pulse();
    check("t5_cnt_held", 32'(cnt), 32'd2);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_no_report", 32'(rpt_if.out_valid), 32'd0);
    start = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_both_busy", 32'(busy), 32'd0);
    check("t5_both_cnt", 32'(cnt), 32'd2);
    step();
    start = 1'b0;
    check("t5_restart_cnt", 32'(cnt), 32'd0);
    check("t5_restart_busy", 32'(busy), 32'd1);

    // interval saturation, then reset while a report is pending
    do_reset();
    term = 8'd1;
    rpt_if.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e < 70000; e++) step();
    pulse();
    check("t6_valid", 32'(rpt_if.out_valid), 32'd1);
    check("t6_cyc_sat", 32'(rpt_if.out_cyc), 32'hFFFF);
    pulse();
    pulse();
    check("t6_lost_set", 32'(lost), 32'd1);
    check("t6_busy_set", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", 32'(rpt_if.out_valid), 32'd0);
    check("t6_rst_lost", 32'(lost), 32'd0);
    check("t6_rst_cnt", 32'(cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 2) == 0) ovflo = ~ovflo;
      term = 8'($urandom_range(0, 4));
      rpt_if.out_ready = 1'($urandom_range(0, 1));
      model_edge(start, stop, ovflo, int'(term), rpt_if.out_ready);
      step();
      check("rnd_cnt", 32'(cnt), 32'(m_cnt));
      check("rnd_busy", 32'(busy), 32'(m_run));
      check("rnd_lost", 32'(lost), 32'(m_lost));
      check("rnd_valid", 32'(rpt_if.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("rnd_seq", 32'(rpt_if.out_seq), 32'(mq[0].seq));
        check("rnd_cyc", 32'(rpt_if.out_cyc), 32'(mq[0].cyc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ovflo_tally.md
Name: ovflo_tally

Overview:
- Downstream consumer of the 3-bit enable counter's `ovflo` flag.
- Detects each rising edge of `ovflo` and tallies overflow events in RUN.
- Every `term` events it emits a report record {sequence number, cycles since the previous report} through a 2-entry valid/ready output buffer.
- Reports feed the host-side statistics logic.

Parameters:
- CNT_W, 8: width of the event tally and of `term`.
- SEQ_W, 4: width of the report sequence number; wraps modulo 2^SEQ_W.
- TS_W, 16: width of the interval field; saturating.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; enter RUN and clear the tally, interval, sequence number and lost flag
- stop  in  1  one-cycle pulse; leave RUN
- ovflo  in  1  overflow level from the upstream counter; may stay high for several cycles
- term  in  CNT_W  events per report; sampled every cycle; 0 is treated as 1
- cnt  out  CNT_W  current tally
- busy  out  1  high in RUN
- lost  out  1  sticky; a report was dropped because the buffer was full
- out_valid  out  1  report available
- out_ready  in  1  consumer accepts the report when high together with out_valid
- out_seq  out  SEQ_W  report sequence number
- out_cyc  out  TS_W  interval covered by the report

Behaviour:
- Reset: on the next edge, all outputs, the edge register, the interval counter, the FIFO pointers and occupancy go to 0, and state goes to IDLE. Reset wins over every other input, including mid-transfer with out_valid=1.
- Edge detect:
  - ovf_d <= ovflo every cycle, in every state.
  - evt = ovflo & ~ovf_d.
  - ovflo held high for N cycles produces exactly one evt.
- FSM states IDLE and RUN:
  - IDLE to RUN on start.
  - RUN to IDLE on stop.
  - If start and stop are asserted together, stop wins: the block stays in or goes to IDLE, and start's clears do not occur.
  - start while already in RUN re-applies the clears and stays in RUN.
- start clears: cnt<=0, seq<=0, lost<=0, cyc<=1. The FIFO is not flushed.
- Interval counter cyc:
  - In RUN, cyc<=cyc+1 each cycle, saturating at all-ones.
  - Held in IDLE.
- Tally, evaluated in RUN only:
  - On evt with cnt+1 >= max(term,1), this is a terminal event: push {seq, cyc}, then cnt<=0, seq<=seq+1, cyc<=1.
  - On evt otherwise, cnt<=cnt+1.
  - If term is lowered below cnt, the next evt is terminal.
- IDLE: evt is ignored; cnt, seq and cyc are held.
- Output FIFO, 2 entries:
  - A push is visible on out_* the cycle after the terminal event (1-cycle latency).
  - out_valid = not empty; head data is stable while out_valid & ~out_ready.
  - Pop on out_valid & out_ready.
  - Push while full with no pop that cycle: the record is dropped, lost<=1, and seq still increments.
  - Push while full with a pop in the same cycle: the push is accepted.
  - Push while empty: valid next cycle. No same-cycle bypass.
- stop mid-count: cnt is held and the FIFO keeps draining.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=0, RUN=1.
  - Record width REC_W = SEQ_W + TS_W.
  - Field offsets within the record.
- One natural sub-module: ovflo_rpt_fifo. It is a 2-deep, REC_W-wide synchronous FIFO with push, pop, full, empty and a drop indication.

Test Plan:
- Reset, start at cycle 0, term=3, one-cycle ovflo pulses at cycles 5, 13, 21, out_ready=1 -> cycle 22: out_valid=1, out_seq=0, out_cyc=21; then cnt=0. A 4th pulse at cycle 45 does not report (cnt=1).
- term=2, ovflo held high for cycles 5-9, then pulse at 15 -> one evt each; report at cycle 16 with out_cyc=15; the held level does not add extra counts.
- term=1, out_ready=0, pulses at 5, 10, 15 -> two records held (seq 0 with cyc 5, seq 1 with cyc 5), lost=1 from cycle 16. Raising ready then drains seq 0 then seq 1, and the next report carries seq=3.
- FIFO full, out_ready=1 in the same cycle as a terminal event -> push accepted, lost stays 0, 2 entries remain.
- term=5, 2 events, stop, 3 more pulses -> cnt=2, busy=0, no report. start and stop in the same cycle -> stays IDLE. Then start -> cnt=0, busy=1.
- term=1, no event for 70000 RUN cycles, then a pulse -> out_cyc=16'hFFFF. Assert rst while out_valid=1 -> out_valid, lost, cnt and busy are 0 on the next cycle.
